iob_split_pipe: RTL and testbench

- Registered, parametrised successor to the native iob bus splitter: routes one master request to one of N_SLAVES by an address selector field.
- Adds one request pipeline stage, unmapped-address error responses, per-transaction timeout, and a saturating error counter.
- Sits between CPU/peripheral bus and slave buses wherever a plain split is used today.
- Enables the peripheral split to meet timing and prevents a hung slave from locking the CPU.

---
 rtl/iob_split_pipe_pkg.sv | 17 +
 rtl/iob_sat_counter.sv | 19 +
 rtl/iob_split_pipe.sv | 134 +++++++++++++
 tb/tb_iob_split_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/iob_split_pipe_pkg.sv
// Shared types and helpers for the registered iob splitter.
package iob_split_pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  // Selector width for n slaves, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iob_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module iob_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/iob_split_pipe.sv
// Registered one-master to N-slave iob splitter with unmapped-address
// errors, per-transaction timeout and a saturating error counter.
module iob_split_pipe
  import iob_split_pipe_pkg::*;
#(
  parameter int unsigned          N_SLAVES = 2,
  parameter int unsigned          P_SLAVES = 31,
  parameter int unsigned          SEL_W    = sel_width(N_SLAVES),
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          TIMEOUT  = 256,
  parameter logic [DATA_W-1:0]    ERR_DATA = DATA_W'(ERR_DATA_DEF),
  parameter int unsigned          CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_ready,
  output logic                         m_err,
  output logic [N_SLAVES-1:0]          s_valid,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
  input  logic [N_SLAVES-1:0]          s_ready,
  output logic [CNT_W-1:0]             err_count
);

  localparam int unsigned TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMR_MAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_e             state, state_nxt;
  logic [SEL_W-1:0]   sel, sel_q;
  logic               sel_ok;
  logic [TMR_W-1:0]   tmr;
  logic               tmo;
  logic               sel_ready;
  logic [DATA_W-1:0]  sel_rdata;

  assign sel    = m_addr[P_SLAVES -: SEL_W];
  assign sel_ok = 32'(sel) < N_SLAVES;
  assign tmo    = (TIMEOUT != 0) && (tmr == TMR_W'(TMR_MAX));

  // Response mux for the latched slave; out-of-range selects read as idle.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (m_valid) state_nxt = sel_ok ? ST_BUSY : ST_ERR;
      ST_BUSY: if (sel_ready || tmo) state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Slave response wins over a timeout landing in the same cycle.
  always_comb begin
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
    case (state)
      ST_BUSY: begin
        if (sel_ready) begin
          m_ready = 1'b1;
          m_rdata = sel_rdata;
        end else if (tmo) begin
          m_ready = 1'b1;
          m_err   = 1'b1;
          m_rdata = ERR_DATA;
        end
      end
      ST_ERR: begin
        m_ready = 1'b1;
        m_err   = 1'b1;
        m_rdata = ERR_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      sel_q   <= '0;
      tmr     <= '0;
    end else if (state == ST_IDLE) begin
      if (m_valid && sel_ok) begin
        s_valid <= N_SLAVES'(1) << sel;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_wstrb <= m_wstrb;
        sel_q   <= sel;
      end
      tmr <= '0;
    end else if (state == ST_BUSY) begin
      if (state_nxt == ST_IDLE) begin
        s_valid <= '0;
        tmr     <= '0;
      end else begin
        tmr <= tmr + TMR_W'(1);
      end
    end
  end

  iob_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (m_err),
    .count (err_count)
  );

endmodule

// File: tb/tb_iob_split_pipe.sv
// Directed-vector bench for iob_split_pipe with 3 slaves and an 8-cycle timeout.
module tb_iob_split_pipe;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk, rst;
  logic            m_valid;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic            m_ready, m_err;
  logic [N-1:0]    s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_ready;
  logic [15:0]     err_count;

  logic [DW-1:0]   x_rdata;
  logic            x_ready, x_err;
  logic [N-1:0]    x_valid;
  logic [AW-1:0]   x_addr;
  logic [DW-1:0]   x_wdata;
  logic [DW/8-1:0] x_wstrb;
  logic [1:0]      x_count;

  int n_vec = 0;
  int n_mis = 0;

  iob_split_pipe #(.N_SLAVES(3), .P_SLAVES(31), .ADDR_W(32), .DATA_W(32),
                   .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .m_ready(m_ready), .m_err(m_err), .s_valid(s_valid), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready), .err_count(err_count)
  );

  // Narrow-counter twin sharing all inputs, to reach saturation quickly.
  iob_split_pipe #(.N_SLAVES(3), .P_SLAVES(31), .ADDR_W(32), .DATA_W(32),
                   .TIMEOUT(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(x_rdata),
    .m_ready(x_ready), .m_err(x_err), .s_valid(x_valid), .s_addr(x_addr),
    .s_wdata(x_wdata), .s_wstrb(x_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready), .err_count(x_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_ready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    next_cyc();
    next_cyc();
    @(negedge clk);
    n_vec++; if (s_valid !== 3'b000) begin n_mis++; $display("FAIL rst_svalid: got %b want 000", s_valid); end
    n_vec++; if (m_ready !== 1'b0 || m_err !== 1'b0) begin n_mis++; $display("FAIL rst_mready: got %b/%b want 0/0", m_ready, m_err); end
    n_vec++; if (err_count !== 16'h0) begin n_mis++; $display("FAIL rst_errcnt: got %h want 0000", err_count); end
    n_vec++; if (s_addr !== 32'h0 || m_rdata !== 32'h0) begin n_mis++; $display("FAIL rst_data: got %h/%h want 0/0", s_addr, m_rdata); end
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_read();
    m_valid = 1'b1; m_addr = 32'h4000_0010; m_wstrb = 4'h0;
    @(negedge clk);
    n_vec++; if (m_ready !== 1'b0) begin n_mis++; $display("FAIL rd_c0_ready: got %b want 0", m_ready); end
    next_cyc();
    @(negedge clk);
    n_vec++; if (s_valid !== 3'b010) begin n_mis++; $display("FAIL rd_c1_svalid: got %b want 010", s_valid); end
    n_vec++; if (s_addr !== 32'h4000_0010) begin n_mis++; $display("FAIL rd_c1_saddr: got %h want 40000010", s_addr); end
    next_cyc();
    s_ready = 3'b001;
    s_rdata[0 +: 32] = 32'h5555_AAAA;
    @(negedge clk);
    n_vec++; if (m_ready !== 1'b0 || s_valid !== 3'b010) begin n_mis++; $display("FAIL rd_c2_foreign_ready: got %b/%b want 0/010", m_ready, s_valid); end
    next_cyc();
    s_ready = 3'b010;
    s_rdata[32 +: 32] = 32'h1234_5678;
    @(negedge clk);
    n_vec++; if (m_ready !== 1'b1 || m_err !== 1'b0) begin n_mis++; $display("FAIL rd_c3_resp: got %b/%b want 1/0", m_ready, m_err); end
    n_vec++; if (m_rdata !== 32'h1234_5678) begin n_mis++; $display("FAIL rd_c3_rdata: got %h want 12345678", m_rdata); end
    n_vec++; if (s_valid !== 3'b010) begin n_mis++; $display("FAIL rd_c3_svalid: got %b want 010", s_valid); end
    next_cyc();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (s_valid !== 3'b000 || m_ready !== 1'b0 || m_rdata !== 32'h0) begin n_mis++; $display("FAIL rd_c4_idle: got %b/%b/%h want 000/0/0", s_valid, m_ready, m_rdata); end
    next_cyc();
  endtask

  task automatic test_back_to_back();
    m_valid = 1'b1; m_addr = 32'h0000_0004; m_wdata = 32'hA5A5_A5A5; m_wstrb = 4'hF;
    next_cyc();
    s_ready = 3'b001;
    s_rdata[0 +: 32] = 32'h1111_0000;
    @(negedge clk);
    n_vec++; if (s_valid !== 3'b001) begin n_mis++; $display("FAIL b2b_c1_svalid: got %b want 001", s_valid); end
    n_vec++; if (s_wdata !== 32'hA5A5_A5A5 || s_wstrb !== 4'hF || s_addr !== 32'h4) begin n_mis++; $display("FAIL b2b_c1_wr: got %h/%h/%h want a5a5a5a5/f/4", s_wdata, s_wstrb, s_addr); end
    n_vec++; if (m_ready !== 1'b1 || m_rdata !== 32'h1111_0000) begin n_mis++; $display("FAIL b2b_c1_resp: got %b/%h want 1/11110000", m_ready, m_rdata); end
    next_cyc();
    s_ready = '0;
    m_addr = 32'h8000_0000; m_wdata = '0; m_wstrb = 4'h0;
    @(negedge clk);
    n_vec++; if (s_valid !== 3'b000 || m_ready !== 1'b0) begin n_mis++; $display("FAIL b2b_c2_gap: got %b/%b want 000/0", s_valid, m_ready); end
    next_cyc();
    s_ready = 3'b100;
    s_rdata[64 +: 32] = 32'h0BAD_CAFE;
    @(negedge clk);
    n_vec++; if (s_valid !== 3'b100 || s_addr !== 32'h8000_0000 || s_wstrb !== 4'h0) begin n_mis++; $display("FAIL b2b_c3_req: got %b/%h/%h want 100/80000000/0", s_valid, s_addr, s_wstrb); end
    n_vec++; if (m_ready !== 1'b1 || m_rdata !== 32'h0BAD_CAFE) begin n_mis++; $display("FAIL b2b_c3_resp: got %b/%h want 1/0badcafe", m_ready, m_rdata); end
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_unmapped();
    m_valid = 1'b1; m_addr = 32'hC000_0000;
    next_cyc();
    @(negedge clk);
    n_vec++; if (s_valid !== 3'b000) begin n_mis++; $display("FAIL um_svalid: got %b want 000", s_valid); end
    n_vec++; if (m_ready !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL um_resp: got %b/%b/%h want 1/1/deadbeef", m_ready, m_err, m_rdata); end
    next_cyc();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (err_count !== 16'd1 || m_ready !== 1'b0) begin n_mis++; $display("FAIL um_errcnt: got %0d/%b want 1/0", err_count, m_ready); end
    next_cyc();
  endtask

  task automatic test_timeout();
    m_valid = 1'b1; m_addr = 32'h8000_0000;
    for (int k = 1; k <= 7; k++) begin
      next_cyc();
      @(negedge clk);
      n_vec++; if (m_ready !== 1'b0 || s_valid !== 3'b100) begin n_mis++; $display("FAIL to_wait_c%0d: got %b/%b want 0/100", k, m_ready, s_valid); end
    end
    next_cyc();
    @(negedge clk);
    n_vec++; if (m_ready !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL to_c8_resp: got %b/%b/%h want 1/1/deadbeef", m_ready, m_err, m_rdata); end
    next_cyc();
    m_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (s_valid !== 3'b000 || err_count !== 16'd2) begin n_mis++; $display("FAIL to_c9: got %b/%0d want 000/2", s_valid, err_count); end
    next_cyc();
    s_ready = 3'b100;
    s_rdata[64 +: 32] = 32'h7777_7777;
    @(negedge clk);
    n_vec++; if (m_ready !== 1'b0 || m_err !== 1'b0 || m_rdata !== 32'h0) begin n_mis++; $display("FAIL to_c10_late: got %b/%b/%h want 0/0/0", m_ready, m_err, m_rdata); end
    next_cyc();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (err_count !== 16'd2 || s_valid !== 3'b000) begin n_mis++; $display("FAIL to_c11: got %0d/%b want 2/000", err_count, s_valid); end
    next_cyc();
  endtask

  task automatic test_coincide();
    m_valid = 1'b1; m_addr = 32'h4000_0000;
    for (int k = 1; k <= 7; k++) next_cyc();
    next_cyc();
    s_ready = 3'b010;
    s_rdata[32 +: 32] = 32'hCAFE_F00D;
    @(negedge clk);
    n_vec++; if (m_ready !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'hCAFE_F00D) begin n_mis++; $display("FAIL co_c8: got %b/%b/%h want 1/0/cafef00d", m_ready, m_err, m_rdata); end
    next_cyc();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (err_count !== 16'd2 || s_valid !== 3'b000) begin n_mis++; $display("FAIL co_c9: got %0d/%b want 2/000", err_count, s_valid); end
    next_cyc();
  endtask

  task automatic test_rst_busy();
    m_valid = 1'b1; m_addr = 32'h0000_0100; m_wdata = 32'h0F0F_0F0F; m_wstrb = 4'h3;
    next_cyc();
    @(negedge clk);
    n_vec++; if (s_valid !== 3'b001 || s_wstrb !== 4'h3) begin n_mis++; $display("FAIL rb_c1: got %b/%h want 001/3", s_valid, s_wstrb); end
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_vec++; if (s_valid !== 3'b000 || s_addr !== 32'h0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin n_mis++; $display("FAIL rb_c3_sbus: got %b/%h/%h/%h want all 0", s_valid, s_addr, s_wdata, s_wstrb); end
    n_vec++; if (m_ready !== 1'b0 || m_err !== 1'b0 || m_rdata !== 32'h0 || err_count !== 16'h0) begin n_mis++; $display("FAIL rb_c3_mbus: got %b/%b/%h/%h want all 0", m_ready, m_err, m_rdata, err_count); end
    next_cyc();
  endtask

  task automatic test_saturation();
    logic [1:0] want_sat;
    for (int k = 1; k <= 4; k++) begin
      m_valid = 1'b1; m_addr = 32'hC000_0000;
      next_cyc();
      next_cyc();
      m_valid = 1'b0;
      @(negedge clk);
      want_sat = (k >= 3) ? 2'd3 : 2'(k);
      n_vec++; if (x_count !== want_sat) begin n_mis++; $display("FAIL sat_narrow_%0d: got %0d want %0d", k, x_count, want_sat); end
      n_vec++; if (err_count !== 16'(k)) begin n_mis++; $display("FAIL sat_wide_%0d: got %0d want %0d", k, err_count, k); end
      next_cyc();
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_unmapped();
    test_timeout();
    test_coincide();
    test_rst_busy();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
